// File: rtl/tt_input_conditioner.sv
// tt_input_conditioner
//   Conditions raw dedicated pad inputs before they reach the core: a
//   two-flop synchronizer, optional per-bit debounce, rising-edge detect,
//   and a small event FIFO of rise masks drained by valid/ready.
//
//   Build option: define INPUT_DEBOUNCE_EN to include the per-bit debounce
//   counters. Without it the conditioned level follows the synchronizer
//   output every cycle and DEBOUNCE_CYCLES is ignored.
//
// Parameters
//   WIDTH           number of input bits conditioned
//   DEBOUNCE_CYCLES cycles a changed synchronized bit must hold (>= 1)
//   FIFO_DEPTH      event FIFO entries (power of two, >= 2)
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   ui_in      in   raw asynchronous pad inputs
//   level_out  out  conditioned, stable input levels
//   rise_pulse out  one-cycle pulse per bit on a 0->1 of level_out
//   evt_valid  out  event FIFO non-empty
//   evt_data   out  rise mask at FIFO head (meaningless when !evt_valid)
//   evt_ready  in   consumer accepts the head entry this cycle
//   ovf        out  sticky: an event was dropped because the FIFO was full
//   ovf_clr    in   clears ovf (a simultaneous drop wins)

module tt_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ui_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("tt_input_conditioner: illegal DEBOUNCE_CYCLES or FIFO_DEPTH");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_next;
  logic [WIDTH-1:0] rise_q;

  // ---------------------------------------------------------------------
  // Debounce: level_next is the value level takes at the next edge, so the
  // edge detector can register the rise in the same edge as the level.
  // ---------------------------------------------------------------------
`ifdef INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_next;

  always_comb begin
    level_next = level;
    cnt_next   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  assign level_next = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      rise_q <= '0;
    end else begin
      sync1  <= ui_in;
      sync2  <= sync1;
      level  <= level_next;
      rise_q <= level_next & ~level;
    end
  end

  assign level_out  = level;
  assign rise_pulse = rise_q;

  // ---------------------------------------------------------------------
  // Event FIFO. Pointers carry one extra wrap bit so full and empty are
  // distinguishable without a separate counter register.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign push  = |rise_q;
  assign pop   = ~empty & evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rise_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  assign evt_valid = ~empty;
  assign evt_data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_tt_input_conditioner.sv
module tb_tt_input_conditioner;

  localparam int WIDTH = 8;
  localparam int DB    = 4;
  localparam int DEPTH = 4;
`ifdef INPUT_DEBOUNCE_EN
  localparam int DB_EFF = DB;
`else
  localparam int DB_EFF = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] ui_in = '0;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_pulse;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ready = 1'b0;
  logic             ovf;
  logic             ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  tt_input_conditioner #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .level_out(level_out),
    .rise_pulse(rise_pulse), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] exp_q [4];

  initial begin
    // ---------------- reset state ----------------
    ui_in = 8'h00;
    tick(3);
    chk("rst_level", level_out, 8'h00);
    chk("rst_rise", rise_pulse, 8'h00);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    tick(3);

    // ---------------- clean press ----------------
    ui_in = 8'h01;
    for (int t = 1; t <= DB_EFF + 3; t++) begin
      tick();
      chk($sformatf("press_level_t%0d", t), level_out, (t >= DB_EFF + 2) ? 8'h01 : 8'h00);
      chk($sformatf("press_rise_t%0d", t), rise_pulse, (t == DB_EFF + 2) ? 8'h01 : 8'h00);
      chk($sformatf("press_valid_t%0d", t), evt_valid, (t >= DB_EFF + 3) ? 1'b1 : 1'b0);
    end
    chk("press_data", evt_data, 8'h01);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("press_popped", evt_valid, 1'b0);
    ui_in = 8'h00;
    tick(DB_EFF + 4);
    chk("release_level", level_out, 8'h00);
    chk("release_no_evt", evt_valid, 1'b0);

`ifdef INPUT_DEBOUNCE_EN
    // ---------------- glitch (3 cycles) ----------------
    ui_in = 8'h08;
    tick(3);
    ui_in = 8'h00;
    for (int t = 4; t <= 12; t++) begin
      tick();
      chk($sformatf("glitch_level_t%0d", t), level_out, 8'h00);
      chk($sformatf("glitch_rise_t%0d", t), rise_pulse, 8'h00);
      chk($sformatf("glitch_valid_t%0d", t), evt_valid, 1'b0);
    end
`endif

    // ---------------- 4-cycle pulse on bit 3 ----------------
    ui_in = 8'h08;
    for (int t = 1; t <= DB_EFF + 3; t++) begin
      tick();
      if (t == 4) ui_in = 8'h00;
      if (t == DB_EFF + 2) begin
        chk("pulse4_level", level_out, 8'h08);
        chk("pulse4_rise", rise_pulse, 8'h08);
      end
      if (t == DB_EFF + 3) begin
        chk("pulse4_valid", evt_valid, 1'b1);
        chk("pulse4_data", evt_data, 8'h08);
      end
    end
    ui_in = 8'h00;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    tick(DB_EFF + 6);
    chk("pulse4_settle_level", level_out, 8'h00);
    chk("pulse4_settle_valid", evt_valid, 1'b0);

    // ---------------- simultaneous bits ----------------
    ui_in = 8'h81;
    tick(DB_EFF + 3);
    chk("simul_valid", evt_valid, 1'b1);
    chk("simul_data", evt_data, 8'h81);
    chk("simul_level", level_out, 8'h81);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("simul_single_entry", evt_valid, 1'b0);
    ui_in = 8'h00;
    tick(DB_EFF + 4);

    // ---------------- overflow ----------------
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h04; exp_q[3] = 8'h10;
    ui_in = 8'h01; tick(DB_EFF + 3);
    ui_in = 8'h03; tick(DB_EFF + 3);
    ui_in = 8'h07; tick(DB_EFF + 3);
    ui_in = 8'h17; tick(DB_EFF + 3);
    chk("ovf_before_drop", ovf, 1'b0);
    ui_in = 8'h37; tick(DB_EFF + 3);
    chk("ovf_after_drop", ovf, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 1'b0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_valid_%0d", j), evt_valid, 1'b1);
      chk($sformatf("drain_data_%0d", j), evt_data, exp_q[j]);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    chk("drain_empty", evt_valid, 1'b0);
    ui_in = 8'h00;
    tick(DB_EFF + 4);

    // ---------------- full with push and pop together ----------------
    ui_in = 8'h01; tick(DB_EFF + 3);
    ui_in = 8'h03; tick(DB_EFF + 3);
    ui_in = 8'h07; tick(DB_EFF + 3);
    ui_in = 8'h0F; tick(DB_EFF + 3);
    ui_in = 8'h1F;
    tick(DB_EFF + 2);
    chk("fullpp_rise", rise_pulse, 8'h10);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("fullpp_ovf", ovf, 1'b0);
    exp_q[0] = 8'h02; exp_q[1] = 8'h04; exp_q[2] = 8'h08; exp_q[3] = 8'h10;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("fullpp_valid_%0d", j), evt_valid, 1'b1);
      chk($sformatf("fullpp_data_%0d", j), evt_data, exp_q[j]);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    chk("fullpp_empty", evt_valid, 1'b0);
    ui_in = 8'h00;
    tick(DB_EFF + 4);

    // ---------------- reset mid-debounce with queued events ----------------
    ui_in = 8'h01; tick(DB_EFF + 3);
    ui_in = 8'h03; tick(DB_EFF + 3);
    chk("pre_rst_valid", evt_valid, 1'b1);
    ui_in = 8'h07;
    tick(2);
    ui_in = 8'h02;
    rst_n = 1'b0;
    #1;
    chk("midrst_level", level_out, 8'h00);
    chk("midrst_rise", rise_pulse, 8'h00);
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    tick(3);
    rst_n = 1'b1;
    for (int t = 1; t <= DB_EFF + 3; t++) begin
      tick();
      chk($sformatf("postrst_level_t%0d", t), level_out, (t >= DB_EFF + 2) ? 8'h02 : 8'h00);
      chk($sformatf("postrst_rise_t%0d", t), rise_pulse, (t == DB_EFF + 2) ? 8'h02 : 8'h00);
      chk($sformatf("postrst_valid_t%0d", t), evt_valid, (t >= DB_EFF + 3) ? 1'b1 : 1'b0);
    end
    chk("postrst_data", evt_data, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
